// File: rtl/ap_line_pkg.sv
// ap_line_pkg: shared types for the AP line dispatcher slice.
//   opcode_e     - 4-bit decoded instruction opcode (NOP, INC, DEC, RIGHT, LEFT, OUT, IN, TEST)
//   dispState_e  - dispatcher FSM state encoding
//   DATA_W_DEFAULT - default cell width, must match the AP line data width
//   isRepeatOp   - true for opcodes that honour the repeat count
package ap_line_pkg;

  localparam int unsigned DATA_W_DEFAULT = 10;

  typedef enum logic [3:0] {
    NOP   = 4'd0,
    INC   = 4'd1,
    DEC   = 4'd2,
    RIGHT = 4'd3,
    LEFT  = 4'd4,
    OUT   = 4'd5,
    IN    = 4'd6,
    TEST  = 4'd7
  } opcode_e;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_RDY,
    STEP,
    SETTLE_W,
    STEP_RDY,
    OUT_HOLD,
    IN_WAIT,
    RETIRE,
    FAULT
  } dispState_e;

  function automatic logic isRepeatOp(input opcode_e op);
    return op inside {INC, DEC, RIGHT, LEFT};
  endfunction

endpackage

// File: rtl/rep_down_counter.sv
// rep_down_counter: loadable down-counter holding the remaining repeat count.
//   Clk, Rst_n  - clock, asynchronous active-low reset
//   Load        - load LoadValue (has priority over Dec)
//   LoadValue   - REP_W-bit value to load
//   Dec         - decrement by one; saturates at zero
//   Zero        - count is zero
module rep_down_counter #(
  parameter int unsigned REP_W = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Load,
  input  logic [REP_W-1:0] LoadValue,
  input  logic             Dec,
  output logic             Zero
);

  logic [REP_W-1:0] count;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count <= '0;
    end else if (Load) begin
      count <= LoadValue;
    end else if (Dec && (count != '0)) begin
      count <= count - REP_W'(1);
    end
  end

  assign Zero = (count == '0);

endmodule

// File: rtl/ap_line_dispatcher.sv
// ap_line_dispatcher: executes decoded + - > < . , and zero-test instructions
// against the AP line, turning each into paced single-cycle ack pulses.
//
// Ports:
//   Clk, Rst_n            - clock, asynchronous active-low reset
//   InsnValid/InsnReady   - instruction handshake from the decoder
//   InsnOp, InsnRep       - opcode and repeat count (0 treated as 1)
//   ApCountAck            - pointer step pulse to the AP line
//   DataCountAck          - data step pulse to the AP line
//   DataWriteAck          - stdin store pulse; DataWriteValue valid with it
//   CounterReverse        - direction, 1 for DEC/LEFT, stable per instruction
//   ApLineReady, ApLineData - AP line Ready and DataOut
//   StdoutValid/Ready/Data  - current cell to stdout
//   StdinValid/Ready/Data   - stdin value into the current cell
//   ZeroFlag              - result of the last TEST
//   Done                  - one-cycle pulse when an instruction retires
//   Fault                 - watchdog fault (only with AP_LINE_WATCHDOG_EN)
//
// Build option: define AP_LINE_WATCHDOG_EN to add the TIMEOUT watchdog and
// the Fault port; otherwise Ready is awaited indefinitely.
module ap_line_dispatcher
  import ap_line_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned REP_W  = 4,
  parameter int unsigned SETTLE = 2
`ifdef AP_LINE_WATCHDOG_EN
  ,
  parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              InsnValid,
  output logic              InsnReady,
  input  logic [3:0]        InsnOp,
  input  logic [REP_W-1:0]  InsnRep,
  output logic              ApCountAck,
  output logic              DataCountAck,
  output logic              DataWriteAck,
  output logic              CounterReverse,
  output logic [DATA_W-1:0] DataWriteValue,
  input  logic              ApLineReady,
  input  logic [DATA_W-1:0] ApLineData,
  output logic              StdoutValid,
  input  logic              StdoutReady,
  output logic [DATA_W-1:0] StdoutData,
  input  logic              StdinValid,
  output logic              StdinReady,
  input  logic [DATA_W-1:0] StdinData,
  output logic              ZeroFlag,
  output logic              Done
`ifdef AP_LINE_WATCHDOG_EN
  ,
  output logic              Fault
`endif
);

  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  dispState_e state, nextState;
  opcode_e    opR;
  opcode_e    acceptOp;
  logic       accept;
  logic       repZero;
  logic [REP_W-1:0] repLoad;
  logic [SetW-1:0]  settleCnt;
  logic       settleDone;

  assign acceptOp   = opcode_e'(InsnOp);
  assign accept     = InsnValid && InsnReady;
  assign repLoad    = (isRepeatOp(acceptOp) && (InsnRep != '0)) ? InsnRep : REP_W'(1);
  assign settleDone = (settleCnt == SetW'(SETTLE - 1));

  // Non-repeat ops load 1, so the STEP used by IN leaves reps at zero and
  // STEP_RDY retires it after the settle window.
  rep_down_counter #(
    .REP_W(REP_W)
  ) u_repCnt (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Load     (accept),
    .LoadValue(repLoad),
    .Dec      (state == STEP),
    .Zero     (repZero)
  );

`ifdef AP_LINE_WATCHDOG_EN
  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [WdW-1:0] wdCnt;
  logic           wdExpired;

  assign wdExpired = (wdCnt == WdW'(TIMEOUT - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wdCnt <= '0;
    end else if (((state == WAIT_RDY) || (state == STEP_RDY)) && (nextState == state)) begin
      wdCnt <= wdCnt + WdW'(1);
    end else begin
      wdCnt <= '0;
    end
  end
`endif

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. RETIRE behaves like IDLE for acceptance so Done and
  // InsnReady share a cycle without losing a back-to-back instruction.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE, RETIRE: begin
        if (InsnValid) begin
          if (acceptOp inside {INC, DEC, RIGHT, LEFT, OUT, IN, TEST}) begin
            nextState = WAIT_RDY;
          end else begin
            nextState = RETIRE;
          end
        end else begin
          nextState = IDLE;
        end
      end
      WAIT_RDY: begin
        if (ApLineReady) begin
          case (opR)
            INC, DEC, RIGHT, LEFT: nextState = STEP;
            OUT:                   nextState = OUT_HOLD;
            IN:                    nextState = IN_WAIT;
            default:               nextState = RETIRE;
          endcase
        end
`ifdef AP_LINE_WATCHDOG_EN
        else if (wdExpired) begin
          nextState = FAULT;
        end
`endif
      end
      STEP:     nextState = SETTLE_W;
      SETTLE_W: if (settleDone) nextState = STEP_RDY;
      STEP_RDY: begin
        if (ApLineReady) begin
          nextState = repZero ? RETIRE : STEP;
        end
`ifdef AP_LINE_WATCHDOG_EN
        else if (wdExpired) begin
          nextState = FAULT;
        end
`endif
      end
      OUT_HOLD: if (StdoutReady) nextState = RETIRE;
      IN_WAIT:  if (StdinValid) nextState = STEP;
      FAULT:    nextState = FAULT;
      default:  nextState = IDLE;
    endcase
  end

  // Outputs decoded from state only, so reset clears them asynchronously.
  always_comb begin
    InsnReady    = 1'b0;
    Done         = 1'b0;
    ApCountAck   = 1'b0;
    DataCountAck = 1'b0;
    DataWriteAck = 1'b0;
    StdoutValid  = 1'b0;
    StdinReady   = 1'b0;
`ifdef AP_LINE_WATCHDOG_EN
    Fault        = 1'b0;
`endif
    case (state)
      IDLE:     InsnReady = 1'b1;
      RETIRE: begin
        InsnReady = 1'b1;
        Done      = 1'b1;
      end
      STEP: begin
        ApCountAck   = (opR == RIGHT) || (opR == LEFT);
        DataCountAck = (opR == INC)   || (opR == DEC);
        DataWriteAck = (opR == IN);
      end
      OUT_HOLD: StdoutValid = 1'b1;
      IN_WAIT:  StdinReady  = 1'b1;
`ifdef AP_LINE_WATCHDOG_EN
      FAULT:    Fault       = 1'b1;
`endif
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      opR            <= NOP;
      CounterReverse <= 1'b0;
      StdoutData     <= '0;
      DataWriteValue <= '0;
      ZeroFlag       <= 1'b0;
      settleCnt      <= '0;
    end else begin
      if (accept) begin
        opR            <= acceptOp;
        CounterReverse <= (acceptOp == DEC) || (acceptOp == LEFT);
      end
      if ((state == WAIT_RDY) && ApLineReady) begin
        if (opR == OUT)  StdoutData <= ApLineData;
        if (opR == TEST) ZeroFlag   <= (ApLineData == '0);
      end
      if ((state == IN_WAIT) && StdinValid) begin
        DataWriteValue <= StdinData;
      end
      if ((state == SETTLE_W) && !settleDone) begin
        settleCnt <= settleCnt + SetW'(1);
      end else begin
        settleCnt <= '0;
      end
    end
  end

endmodule
